seq_match_ctrl: RTL and testbench
=================================

Name: seq_match_ctrl

Overview:
Programmable serial-pattern match controller for the TT sequence-detection datapath. It generalises the fixed 11011 Mealy detector into a configurable, armable engine. It loads a PAT_W-bit pattern and an overlap/non-overlap mode, then arms and scans a gated serial bit stream. It emits a same-cycle Mealy match pulse and keeps a saturating match count for the top-level wrapper to expose on uo_out.

Parameters:
PAT_W, 5, pattern length in bits; legal range 2..8.
CNT_W, 8, width of the saturating match counter.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  reset, synchronous, active-low.
cfg_valid  input  1  configuration load request.
cfg_pattern  input  PAT_W  pattern; MSB is the first bit received.
cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
cfg_ready  output  1  high when configuration is accepted, i.e. state is not ARMED.
arm  input  1  start scanning.
disarm  input  1  stop scanning.
bit_valid  input  1  bit_in is sampled this cycle.
bit_in  input  1  serial data bit.
match  output  1  Mealy pulse: the current bit completes the pattern.
match_count  output  CNT_W  number of matches since the last config load; saturates.
state  output  2  FSM state: 0 = IDLE, 1 = CONFIGURED, 2 = ARMED.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low. While rst_n=0 at a clock edge:
  - state=IDLE.
  - pattern register, overlap register, history and fill counter are all 0.
  - match_count=0.
  - match=0 (forced low while rst_n=0).
  - cfg_ready=1.
- Reset asserted mid-scan discards all history. No match fires in the reset cycle.
- FSM:
  - IDLE:
    - cfg_valid → latch cfg_pattern and cfg_overlap, clear match_count, go to CONFIGURED.
    - arm is ignored.
  - CONFIGURED:
    - cfg_valid → reload pattern and mode, clear match_count, stay in CONFIGURED.
    - Else arm & !disarm → go to ARMED with history and fill cleared.
    - cfg_valid has priority over arm in the same cycle.
  - ARMED:
    - disarm → go to CONFIGURED; history and fill cleared; match_count retained.
    - cfg_valid is ignored (cfg_ready=0).
    - arm and disarm together → disarm wins.
- History: a (PAT_W-1)-bit shift register plus a fill counter that saturates at PAT_W-1. Both advance only when state=ARMED and bit_valid=1; new bits shift in at the LSB.
- match (combinational Mealy output) is 1 iff all of the following hold:
  - state=ARMED, bit_valid=1 and rst_n=1;
  - fill==PAT_W-1;
  - {history, bit_in}==pattern.
  - No registered latency: the pulse appears in the same cycle as the completing bit.
- Non-overlap mode: on a match, history and fill clear to 0, so the next match needs PAT_W fresh bits.
- Overlap mode: on a match, history shifts normally and fill stays at PAT_W-1.
- A match in the same cycle as disarm still pulses, and still counts.
- match_count increments by 1 on each match and saturates at 2^CNT_W-1 without wrapping.
- bit_valid=0 cycles are transparent: history, fill and count hold, and match=0.
- Wrapper integration: clk and rst_n come straight from the TT top level; match drives uo_out[0].

Test Plan:
- Reset, then cfg pattern 5'b11011 with overlap=0, arm, stream 1,1,0,1,1,0,1,1 → match only on bit 5; match_count=1; state=2.
- Same stream with overlap=1 → match on bits 5 and 8; match_count=2.
- Stream 1,1,0,1,1 with bit_valid=0 for 3 cycles between each bit → one match on the final valid bit only; match=0 in every gap cycle.
- Arm in IDLE, then feed 11011 → state stays 0, match never asserts. Then cfg, arm, and feed 11011 → match_count=1. Then cfg_valid while ARMED → ignored, cfg_ready=0.
- CNT_W=2, overlap=1, pattern 11, feed 6 ones → match pulses on bits 2..6; match_count steps 1,2,3,3,3 (saturated).
- Mid-pattern (after 1,1,0,1): rst_n=0 for 1 cycle → state=0, match_count=0. Re-config, arm, feed 1 → no match (history was cleared).

Source files
------------

// File: rtl/seq_match_ctrl_if.sv
// rtl/seq_match_ctrl_if.sv - configuration, serial-bit and match-report bundle for seq_match_ctrl
//
// Purpose: carries every seq_match_ctrl signal except clk and rst_n.
// Ports (signals):
//   cfg_valid, cfg_pattern[PAT_W], cfg_overlap  configuration load
//   cfg_ready                                   configuration can be accepted
//   arm, disarm                                 scan control
//   bit_valid, bit_in                           gated serial stream
//   match, match_count[CNT_W], state[2]         results
// Modports: master drives config/stream, slave is the controller.
interface seq_match_ctrl_if #(
   parameter int PAT_W = 5,
   parameter int CNT_W = 8
);
   logic             cfg_valid;
   logic [PAT_W-1:0] cfg_pattern;
   logic             cfg_overlap;
   logic             cfg_ready;
   logic             arm;
   logic             disarm;
   logic             bit_valid;
   logic             bit_in;
   logic             match;
   logic [CNT_W-1:0] match_count;
   logic [1:0]       state;

   modport master (
      output cfg_valid, cfg_pattern, cfg_overlap, arm, disarm, bit_valid, bit_in,
      input  cfg_ready, match, match_count, state
   );

   modport slave (
      input  cfg_valid, cfg_pattern, cfg_overlap, arm, disarm, bit_valid, bit_in,
      output cfg_ready, match, match_count, state
   );
endinterface

// File: rtl/seq_match_ctrl.sv
// rtl/seq_match_ctrl.sv - programmable serial-pattern Mealy match controller with saturating count
//
// Purpose: loads a PAT_W-bit pattern and overlap mode, then when armed scans
// the gated serial stream and pulses match in the same cycle as the bit that
// completes the pattern; counts matches since the last configuration load.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    seq_match_ctrl_if.slave (config, arm/disarm, stream, results)
module seq_match_ctrl #(
   parameter int PAT_W = 5,
   parameter int CNT_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   seq_match_ctrl_if.slave   bus
);
   localparam int FILL_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      CONFIGURED = 2'd1,
      ARMED      = 2'd2
   } state_t;

   state_t             state_q, state_n;
   logic [PAT_W-1:0]   pat_q, pat_n;
   logic               ovl_q, ovl_n;
   logic [PAT_W-2:0]   hist_q, hist_n;
   logic [FILL_W-1:0]  fill_q, fill_n;
   logic [CNT_W-1:0]   cnt_q, cnt_n;
   logic [PAT_W-1:0]   window;
   logic               match_c;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pat_q   <= '0;
         ovl_q   <= 1'b0;
         hist_q  <= '0;
         fill_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_n;
         pat_q   <= pat_n;
         ovl_q   <= ovl_n;
         hist_q  <= hist_n;
         fill_q  <= fill_n;
         cnt_q   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state_q;
      pat_n   = pat_q;
      ovl_n   = ovl_q;
      hist_n  = hist_q;
      fill_n  = fill_q;
      cnt_n   = cnt_q;
      // Oldest history bit lands in the MSB, matching the pattern's first-received MSB.
      window  = {hist_q, bus.bit_in};
      match_c = rst_n && (state_q == ARMED) && bus.bit_valid &&
                (fill_q == FILL_FULL) && (window == pat_q);

      unique case (state_q)
         IDLE: begin
            if (bus.cfg_valid) begin
               pat_n   = bus.cfg_pattern;
               ovl_n   = bus.cfg_overlap;
               cnt_n   = '0;
               state_n = CONFIGURED;
            end
         end
         CONFIGURED: begin
            if (bus.cfg_valid) begin
               pat_n = bus.cfg_pattern;
               ovl_n = bus.cfg_overlap;
               cnt_n = '0;
            end else if (bus.arm && !bus.disarm) begin
               hist_n  = '0;
               fill_n  = '0;
               state_n = ARMED;
            end
         end
         ARMED: begin
            if (bus.bit_valid) begin
               hist_n = window[PAT_W-2:0];
               if (fill_q != FILL_FULL) fill_n = fill_q + FILL_W'(1);
               if (match_c) begin
                  if (cnt_q != CNT_MAX) cnt_n = cnt_q + CNT_W'(1);
                  // Non-overlap mode needs PAT_W fresh bits for the next hit.
                  if (!ovl_q) begin
                     hist_n = '0;
                     fill_n = '0;
                  end
               end
            end
            // Disarm takes effect after this cycle's match has been counted.
            if (bus.disarm) begin
               hist_n  = '0;
               fill_n  = '0;
               state_n = CONFIGURED;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.match       = match_c;
   assign bus.cfg_ready   = (state_q != ARMED);
   assign bus.match_count = cnt_q;
   assign bus.state       = state_q;
endmodule

// File: tb/tb_seq_match_ctrl.sv
// tb/tb_seq_match_ctrl.sv - self-checking bench for seq_match_ctrl (PAT_W=5/CNT_W=8 and PAT_W=2/CNT_W=2)
module tb_seq_match_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       s_rst_n = 1'b0;
   logic       s_cv = 1'b0;
   logic [7:0] s_pat = '0;
   logic       s_ov = 1'b0;
   logic       s_arm = 1'b0;
   logic       s_dis = 1'b0;
   logic       s_bv = 1'b0;
   logic       s_bi = 1'b0;

   seq_match_ctrl_if #(.PAT_W(5), .CNT_W(8)) if5 ();
   seq_match_ctrl_if #(.PAT_W(2), .CNT_W(2)) if2 ();

   assign if5.cfg_valid   = s_cv;
   assign if5.cfg_pattern = s_pat[4:0];
   assign if5.cfg_overlap = s_ov;
   assign if5.arm         = s_arm;
   assign if5.disarm      = s_dis;
   assign if5.bit_valid   = s_bv;
   assign if5.bit_in      = s_bi;
   assign if2.cfg_valid   = s_cv;
   assign if2.cfg_pattern = s_pat[1:0];
   assign if2.cfg_overlap = s_ov;
   assign if2.arm         = s_arm;
   assign if2.disarm      = s_dis;
   assign if2.bit_valid   = s_bv;
   assign if2.bit_in      = s_bi;

   seq_match_ctrl #(.PAT_W(5), .CNT_W(8)) dut5 (.clk(clk), .rst_n(s_rst_n), .bus(if5));
   seq_match_ctrl #(.PAT_W(2), .CNT_W(2)) dut2 (.clk(clk), .rst_n(s_rst_n), .bus(if2));

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: one copy per DUT. History is the chronological list of
   // bits received since arming or since the last non-overlap match.
   int         m_st [2];
   logic [7:0] m_pat [2];
   bit         m_ovl [2];
   int         m_cnt [2];
   int         hlen [2];
   bit         hb [2][16];

   function automatic int pw(input int k);
      return (k == 0) ? 5 : 2;
   endfunction

   function automatic bit exp_match(input int k);
      int p = pw(k);
      if (!s_rst_n || m_st[k] != 2 || !s_bv || hlen[k] < p - 1) return 1'b0;
      for (int i = 0; i < p - 1; i++)
         if (hb[k][hlen[k] - (p - 1) + i] != m_pat[k][p - 1 - i]) return 1'b0;
      return s_bi == m_pat[k][0];
   endfunction

   task automatic push_bit(input int k, input bit b);
      if (hlen[k] == 16) begin
         for (int j = 0; j < 15; j++) hb[k][j] = hb[k][j + 1];
         hlen[k] = 15;
      end
      hb[k][hlen[k]] = b;
      hlen[k]++;
   endtask

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         bit em;
         int cmax;
         em   = exp_match(k);
         cmax = (k == 0) ? 255 : 3;
         if (chk_en) begin
            chk(k == 0 ? "cmp5_match" : "cmp2_match", k == 0 ? 32'(if5.match) : 32'(if2.match), 32'(em));
            chk(k == 0 ? "cmp5_state" : "cmp2_state", k == 0 ? 32'(if5.state) : 32'(if2.state), 32'(m_st[k]));
            chk(k == 0 ? "cmp5_ready" : "cmp2_ready", k == 0 ? 32'(if5.cfg_ready) : 32'(if2.cfg_ready),
                32'(m_st[k] != 2));
            chk(k == 0 ? "cmp5_count" : "cmp2_count", k == 0 ? 32'(if5.match_count) : 32'(if2.match_count),
                32'(m_cnt[k]));
         end
         if (!s_rst_n) begin
            m_st[k] = 0; m_pat[k] = '0; m_ovl[k] = 1'b0; m_cnt[k] = 0; hlen[k] = 0;
         end else begin
            case (m_st[k])
               0: if (s_cv) begin
                     m_pat[k] = s_pat & ((k == 0) ? 8'h1f : 8'h03);
                     m_ovl[k] = s_ov; m_cnt[k] = 0; m_st[k] = 1;
                  end
               1: if (s_cv) begin
                     m_pat[k] = s_pat & ((k == 0) ? 8'h1f : 8'h03);
                     m_ovl[k] = s_ov; m_cnt[k] = 0;
                  end else if (s_arm && !s_dis) begin
                     m_st[k] = 2; hlen[k] = 0;
                  end
               default: begin
                  if (s_bv) begin
                     if (em) begin
                        if (m_cnt[k] < cmax) m_cnt[k]++;
                        if (m_ovl[k]) push_bit(k, s_bi);
                        else hlen[k] = 0;
                     end else push_bit(k, s_bi);
                  end
                  if (s_dis) begin
                     m_st[k] = 1; hlen[k] = 0;
                  end
               end
            endcase
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_cfg(input logic [7:0] p, input logic o);
      s_cv = 1'b1; s_pat = p; s_ov = o;
      tick();
      s_cv = 1'b0;
   endtask

   task automatic do_arm;
      s_arm = 1'b1; tick(); s_arm = 1'b0;
   endtask

   task automatic do_disarm;
      s_dis = 1'b1; tick(); s_dis = 1'b0;
   endtask

   task automatic do_reset(input int n);
      s_rst_n = 1'b0;
      repeat (n) tick();
      s_rst_n = 1'b1;
   endtask

   // Drive one valid bit and check the same-cycle match of the selected DUT.
   task automatic send_bit(input bit b, input bit expm, input int which, input string nm);
      s_bv = 1'b1; s_bi = b;
      #1;
      chk(nm, which == 0 ? 32'(if5.match) : 32'(if2.match), 32'(expm));
      tick();
      s_bv = 1'b0;
   endtask

   task automatic send_gap;
      s_bv = 1'b0; s_bi = 1'($urandom);
      #1;
      chk("gap_match", 32'(if5.match), 0);
      tick();
   endtask

   bit stream8 [8] = '{1, 1, 0, 1, 1, 0, 1, 1};
   bit exp_nov [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
   bit exp_ov  [8] = '{0, 0, 0, 0, 1, 0, 0, 1};
   bit s11011  [5] = '{1, 1, 0, 1, 1};
   int sat_cnt [6] = '{0, 1, 2, 3, 3, 3};

   initial begin
      tick();
      tick();
      s_rst_n = 1'b1;
      chk_en  = 1'b1;
      chk("rst_state", 32'(if5.state), 0);
      chk("rst_count", 32'(if5.match_count), 0);
      chk("rst_ready", 32'(if5.cfg_ready), 1);
      chk("rst_match", 32'(if5.match), 0);

      do_cfg(8'b11011, 1'b0);
      do_arm();
      for (int i = 0; i < 8; i++) send_bit(stream8[i], exp_nov[i], 0, "nov_match");
      chk("nov_count", 32'(if5.match_count), 1);
      chk("nov_state", 32'(if5.state), 2);
      chk("model_nov_count", 32'(m_cnt[0]), 1);

      do_disarm();
      do_cfg(8'b11011, 1'b1);
      do_arm();
      for (int i = 0; i < 8; i++) send_bit(stream8[i], exp_ov[i], 0, "ov_match");
      chk("ov_count", 32'(if5.match_count), 2);
      chk("model_ov_count", 32'(m_cnt[0]), 2);

      do_disarm();
      chk("disarm_keep_count", 32'(if5.match_count), 2);
      do_cfg(8'b11011, 1'b0);
      chk("cfg_clears_count", 32'(if5.match_count), 0);
      do_arm();
      for (int i = 0; i < 5; i++) begin
         send_bit(s11011[i], i == 4, 0, "gap_bit_match");
         if (i < 4) repeat (3) send_gap();
      end
      chk("gap_count", 32'(if5.match_count), 1);

      do_reset(1);
      do_arm();
      for (int i = 0; i < 5; i++) send_bit(s11011[i], 0, 0, "idle_arm_match");
      chk("idle_arm_state", 32'(if5.state), 0);
      do_cfg(8'b11011, 1'b0);
      do_arm();
      for (int i = 0; i < 5; i++) send_bit(s11011[i], i == 4, 0, "armed_match");
      chk("armed_count", 32'(if5.match_count), 1);
      chk("armed_ready", 32'(if5.cfg_ready), 0);
      do_cfg(8'b00000, 1'b1);
      chk("cfg_ignored_count", 32'(if5.match_count), 1);
      chk("cfg_ignored_state", 32'(if5.state), 2);
      for (int i = 0; i < 5; i++) send_bit(s11011[i], i == 4, 0, "cfg_ignored_match");
      chk("cfg_ignored_count2", 32'(if5.match_count), 2);

      do_disarm();
      do_cfg(8'b00000011, 1'b1);
      do_arm();
      for (int i = 0; i < 6; i++) begin
         send_bit(1'b1, i >= 1, 1, "sat_match");
         chk("sat_count", 32'(if2.match_count), 32'(sat_cnt[i]));
      end
      chk("model_sat_count", 32'(m_cnt[1]), 3);

      do_disarm();
      do_cfg(8'b11011, 1'b0);
      do_arm();
      send_bit(1, 0, 0, "pre_rst_match");
      send_bit(1, 0, 0, "pre_rst_match");
      send_bit(0, 0, 0, "pre_rst_match");
      send_bit(1, 0, 0, "pre_rst_match");
      s_bv = 1'b1; s_bi = 1'b1;
      do_reset(1);
      s_bv = 1'b0;
      chk("mid_rst_state", 32'(if5.state), 0);
      chk("mid_rst_count", 32'(if5.match_count), 0);
      do_cfg(8'b11011, 1'b0);
      do_arm();
      send_bit(1, 0, 0, "post_rst_match");
      chk("post_rst_count", 32'(if5.match_count), 0);

      for (int c = 0; c < 4000; c++) begin
         s_rst_n = ($urandom_range(0, 299) != 0);
         s_cv    = ($urandom_range(0, 24) == 0);
         s_pat   = 8'($urandom);
         s_ov    = 1'($urandom);
         s_arm   = ($urandom_range(0, 7) == 0);
         s_dis   = ($urandom_range(0, 59) == 0);
         s_bv    = ($urandom_range(0, 3) != 0);
         s_bi    = 1'($urandom);
         tick();
      end
      s_rst_n = 1'b1; s_cv = 1'b0; s_arm = 1'b0; s_dis = 1'b0; s_bv = 1'b0;
      tick();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
